// File: rtl/issue_dispatch_buffer.sv
// rtl/issue_dispatch_buffer.sv - in-order multi-issue dispatch FIFO between decode and issue
// Optional perf counters (stall_cnt_o, full_cnt_o) enabled by macro CVA6_ISSUE_BUF_PERF_EN.
module issue_dispatch_buffer #(
   parameter int unsigned Depth       = 8,
   parameter int unsigned DecodeWidth = 2,
   parameter int unsigned IssueWidth  = 2,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned NrFu        = 4,
   localparam int unsigned FuBits     = (NrFu > 1) ? $clog2(NrFu) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  flush_i,
   input  logic [DecodeWidth-1:0]                in_valid_i,
   input  logic [DecodeWidth-1:0][DataWidth-1:0] in_data_i,
   input  logic [DecodeWidth-1:0][FuBits-1:0]    in_fu_i,
   output logic [DecodeWidth-1:0]                in_ack_o,
   output logic [IssueWidth-1:0]                 out_valid_o,
   output logic [IssueWidth-1:0][DataWidth-1:0]  out_data_o,
   output logic [IssueWidth-1:0][FuBits-1:0]     out_fu_o,
   input  logic [IssueWidth-1:0]                 operands_ready_i,
   input  logic [NrFu-1:0]                       fu_ready_i,
   output logic [IssueWidth-1:0]                 out_fire_o,
   output logic                                  full_o,
   output logic                                  empty_o
`ifdef CVA6_ISSUE_BUF_PERF_EN
   ,
   output logic [31:0]                           stall_cnt_o,
   output logic [31:0]                           full_cnt_o
`endif
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [PtrW-1:0]      rd_ptr;
   logic [PtrW-1:0]      wr_ptr;
   logic [CntW-1:0]      count;
   logic [CntW-1:0]      free;
   logic [CntW-1:0]      n_ack;
   logic [CntW-1:0]      n_fire;
   logic [DataWidth-1:0] data_mem [Depth];
   logic [FuBits-1:0]    fu_mem   [Depth];
   logic                 ack_prefix;
   logic                 fire_prefix;
   logic                 fu_conflict;
   logic                 fire_j;
   logic [PtrW-1:0]      rd_idx;

   assign free    = CntW'(Depth) - count;
   assign full_o  = (count == CntW'(Depth));
   assign empty_o = (count == '0);

   // Acks are gated by reset too, so decode sees no accept while the buffer is held in reset.
   always_comb begin
      in_ack_o   = '0;
      n_ack      = '0;
      ack_prefix = rst_ni && !flush_i;
      for (int k = 0; k < int'(DecodeWidth); k++) begin
         ack_prefix  = ack_prefix && in_valid_i[k] && (free > CntW'(k));
         in_ack_o[k] = ack_prefix;
         n_ack       = n_ack + CntW'(ack_prefix);
      end
   end

   always_comb begin
      out_valid_o = '0;
      out_data_o  = '0;
      out_fu_o    = '0;
      rd_idx      = '0;
      for (int j = 0; j < int'(IssueWidth); j++) begin
         rd_idx         = rd_ptr + PtrW'(j);
         out_valid_o[j] = !flush_i && (count > CntW'(j));
         out_data_o[j]  = data_mem[rd_idx];
         out_fu_o[j]    = fu_mem[rd_idx];
      end
   end

   // Slot j fires only if every older slot fired and no older slot claimed the same FU class.
   always_comb begin
      out_fire_o  = '0;
      n_fire      = '0;
      fire_prefix = 1'b1;
      fu_conflict = 1'b0;
      fire_j      = 1'b0;
      for (int j = 0; j < int'(IssueWidth); j++) begin
         fu_conflict = 1'b0;
         for (int i = 0; i < j; i++) begin
            if (out_fu_o[i] == out_fu_o[j]) begin
               fu_conflict = 1'b1;
            end
         end
         fire_j        = fire_prefix && out_valid_o[j] && operands_ready_i[j] &&
                         fu_ready_i[out_fu_o[j]] && !fu_conflict;
         out_fire_o[j] = fire_j;
         fire_prefix   = fire_j;
         n_fire        = n_fire + CntW'(fire_j);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            data_mem[i] <= '0;
            fu_mem[i]   <= '0;
         end
      end else if (flush_i) begin
         count  <= '0;
         rd_ptr <= wr_ptr;
      end else begin
         for (int k = 0; k < int'(DecodeWidth); k++) begin
            if (in_ack_o[k]) begin
               data_mem[wr_ptr + PtrW'(k)] <= in_data_i[k];
               fu_mem[wr_ptr + PtrW'(k)]   <= in_fu_i[k];
            end
         end
         wr_ptr <= wr_ptr + PtrW'(n_ack);
         rd_ptr <= rd_ptr + PtrW'(n_fire);
         count  <= count + n_ack - n_fire;
      end
   end

`ifdef CVA6_ISSUE_BUF_PERF_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_o <= '0;
         full_cnt_o  <= '0;
      end else begin
         if ((count != '0) && (n_fire == '0) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (full_o && (full_cnt_o != '1)) begin
            full_cnt_o <= full_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule
